shifter_seq: RTL

Parametrised, multi-cycle shifter/rotator with valid/ready handshakes on its request and result sides. Supports rotate-left, logical left, logical right and arithmetic right shifts of a WIDTH-bit operand. Resolves one shift-amount bit per clock through a single shared shift stage instead of a full combinational barrel. Sits between the ALU operand latches and the result bus, trading latency for a fraction of the mux/buffer chip count.

---
 rtl/shifter_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shifter_seq.sv
// Multi-cycle shifter/rotator: one shift-amount bit is resolved per clock through a
// single shared stage, so every request takes exactly $clog2(WIDTH) cycles.
module shifter_seq #(
    parameter  int WIDTH  = 32,
    localparam int SHFT_W = $clog2(WIDTH)
) (
    input  logic              CLK,
    input  logic              N_RST,
    input  logic [WIDTH-1:0]  IN,
    input  logic [SHFT_W-1:0] SHFT,
    input  logic [1:0]        MODE,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    output logic [WIDTH-1:0]  OUT,
    output logic              OUT_ZERO,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] M_ROL = 2'd0;
    localparam logic [1:0] M_SLL = 2'd1;
    localparam logic [1:0] M_SRL = 2'd2;

    localparam int              CNT_W = (SHFT_W > 1) ? $clog2(SHFT_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHFT_W - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [SHFT_W-1:0] shft_q, shft_d;
    logic [1:0]        mode_q, mode_d;

    logic              accept;
    logic [SHFT_W-1:0] stage_amt;
    logic [SHFT_W-1:0] shft_rem;
    logic [WIDTH-1:0]  stage_out;

    // One stage moves the operand by a power-of-two distance; ROL takes the upper half of
    // the doubled word so the bits leaving the MSB end re-enter at the LSB end.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0]  w,
                                                      input logic [SHFT_W-1:0] amt,
                                                      input logic [1:0]        m);
        logic [2*WIDTH-1:0]      dbl;
        logic signed [WIDTH-1:0] ws;
        logic [WIDTH-1:0]        res;
        dbl = {w, w} << amt;
        ws  = w;
        case (m)
            M_ROL:   res = dbl[2*WIDTH-1:WIDTH];
            M_SLL:   res = w << amt;
            M_SRL:   res = w >> amt;
            default: res = $unsigned(ws >>> amt);
        endcase
        return res;
    endfunction

    assign stage_amt = SHFT_W'(1) << cnt_q;
    assign shft_rem  = shft_q >> cnt_q;
    assign stage_out = shift_stage(work_q, stage_amt, mode_q);

    assign REQ_READY = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY);
    assign accept    = REQ_VALID && REQ_READY;
    assign BUSY      = (state_q == ST_SHIFT);
    assign OUT_VALID = (state_q == ST_DONE);
    assign OUT       = work_q;
    assign OUT_ZERO  = (work_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        shft_d  = shft_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (shft_rem[0]) begin
                    work_d = stage_out;
                end
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (OUT_READY && !REQ_VALID) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Acceptance from IDLE and from DONE (result taken in the same cycle) loads identically.
        if (accept) begin
            work_d  = IN;
            shft_d  = SHFT;
            mode_d  = MODE;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    always_ff @(posedge CLK) begin
        shft_q <= shft_d;
        mode_q <= mode_d;
    end

endmodule
